sequencer_fsm: RTL and testbench
================================

# sequencer_fsm

LUT-driven detector acquisition sequencer. Software preloads a 29-bit-wide sequence table while the block is held in reset. After reset release the FSM walks the table entry by entry, dwelling in each entry's panel state for a programmed time. It drives one-hot phase enables (panel, bias, flush, expose, readout, AED) to the panel timing logic.

## Interface
- `LUT_DEPTH`, 16: number of table entries; address width is clog2(`LUT_DEPTH`).
- `clk` in 1: single clock; all logic is rising-edge.
- `reset_i` in 1: synchronous, active-low reset.
- `lut_wen_i` in 1: table write strobe; honoured only while `reset_i`=0.
- `lut_write_data_i` in 29: entry fields:
  - [28:21] repeat count
  - [20:5] data length (dwell)
  - [4] EOF
  - [3] SOF
  - [2:0] state code
- `lut_rden_i` in 1: table read strobe.
- `current_state_o` out 3: state code.
- `busy_o` out 1: 1 in any state other than RST or IDLE.
- `sequence_done_o` out 1: one-cycle pulse at end of sequence.
- `lut_read_data_o` out 29: registered table read data.
- `panel_enable_o`, `bias_enable_o`, `flush_enable_o`, `expose_enable_o`, `readout_enable_o`, `aed_enable_o` out 1 each: phase enables.
- `current_repeat_count_o` out 8: remaining repetitions of the active entry, including the current one.
- `current_data_length_o` out 16: active entry dwell field.
- `current_eof_o`, `current_sof_o` out 1 each: active entry flags.

## Operation
- State codes are compilation-unit-scope constants visible to benches:
  - RST=0, IDLE=1, PANEL_STABLE=2, BACK_BIAS=3, FLUSH=4, AED_DETECT=5, EXPOSE_TIME=6, READOUT=7.
- Internal pointer `lut_addr_reg` (bench-probed) serves as both the write pointer and the sequence pointer. Entry count `lut_count` is a separate internal register.
- While reset is asserted:
  - FSM is held in RST and all outputs are 0.
  - `lut_wen_i`=1: write entry to LUT[`lut_addr_reg`], increment the pointer, set `lut_count` = pointer+1.
  - `lut_wen_i`=0: clear the pointer (the table is kept).
  - Writes with pointer = `LUT_DEPTH`-1 already written are ignored; the pointer saturates.
- Writes while not in reset are ignored.
- RST → IDLE on the first clock with `reset_i`=1; `lut_addr_reg` is cleared to 0 on the same edge.
- IDLE:
  - `lut_count`=0: stay in IDLE.
  - Otherwise load LUT[`lut_addr_reg`] into the active-entry registers and jump to its state code.
- Active entry:
  - Dwell is max(data length, 1) cycles per repetition.
  - A repeat count of 0 is treated as 1.
  - `current_repeat_count_o` decrements at the end of each repetition.
- After the last repetition, if EOF=0 and `lut_addr_reg`+1 < `lut_count`:
  - Increment the pointer, load the next entry, and enter its state directly with no IDLE gap.
- Otherwise the sequence ends:
  - Pulse `sequence_done_o`, go to IDLE, clear the pointer.
- Entry state codes 0 or 1 end the sequence immediately with a `sequence_done_o` pulse.
- Enables are a combinational decode of the state register; exactly one is high in each non-RST/IDLE state.
- Active-entry outputs are 0 in RST and IDLE.
- Table read: when `lut_rden_i`=1, `lut_read_data_o` <= LUT[`lut_addr_reg`]; otherwise it holds. Reset value is 0.

## Timing
- After reset release:
  - Cycle 1: IDLE.
  - Cycle 2: first entry state.
- Each state lasts exactly repeat × max(len, 1) cycles; there is no transition overhead between entries.
- `sequence_done_o` is high for 1 cycle, coincident with the first IDLE cycle.
- Table read latency is 1 cycle.
- Reset asserted mid-sequence returns to RST on the next edge; the table contents are preserved.

## Configuration
- `SEQ_AUTO_LOOP_EN` defined: after `sequence_done_o`, IDLE restarts the table from entry 0 on the next cycle.
- `SEQ_AUTO_LOOP_EN` undefined: the FSM parks in IDLE until the next reset.

## Test plan
- Reset for 10 cycles, then write 5 entries during reset; release reset.
  - Required: `lut_addr_reg` 0→5 during the writes, and `lut_count`=5.
- Entries: {5,100,PANEL_STABLE}, {1,0,BACK_BIAS}, {3,256,FLUSH}, {1,5000,EXPOSE_TIME}, {1,4096,EOF,READOUT}.
  - Required: PANEL_STABLE for 500 cycles with the repeat count stepping 5→1 every 100 cycles.
  - Then BACK_BIAS for 1 cycle.
  - Then FLUSH for 768 cycles.
  - Then EXPOSE_TIME for 5000 cycles, with `expose_enable_o` the only enable high.
- Continue the previous sequence.
  - Required: READOUT for 4096 cycles, `current_eof_o`=1, then a single `sequence_done_o` pulse, IDLE, `busy_o`=0.
- Release reset with no entries written.
  - Required: FSM stays in IDLE, `busy_o`=0, no done pulse.
- Assert reset mid-FLUSH, then release.
  - Required: RST with all outputs 0 next cycle; the sequence restarts at entry 0 with the table intact.
- Pulse `lut_rden_i` with `lut_addr_reg`=2.
  - Required: `lut_read_data_o` = {3,256,0,0,4} one cycle later, then held.

Source files
------------

// File: rtl/sequencer_fsm.sv
// LUT-driven acquisition sequencer: walks a table preloaded during reset, dwelling per entry.
// Optional SEQ_AUTO_LOOP_EN: restart from entry 0 after each sequence instead of parking in IDLE.
typedef enum logic [2:0] {
  RST          = 3'd0,
  IDLE         = 3'd1,
  PANEL_STABLE = 3'd2,
  BACK_BIAS    = 3'd3,
  FLUSH        = 3'd4,
  AED_DETECT   = 3'd5,
  EXPOSE_TIME  = 3'd6,
  READOUT      = 3'd7
} seq_state_e;

module sequencer_fsm #(
  parameter int LUT_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic        lut_wen_i,
  input  logic [28:0] lut_write_data_i,
  input  logic        lut_rden_i,
  output logic [2:0]  current_state_o,
  output logic        busy_o,
  output logic        sequence_done_o,
  output logic [28:0] lut_read_data_o,
  output logic        panel_enable_o,
  output logic        bias_enable_o,
  output logic        flush_enable_o,
  output logic        expose_enable_o,
  output logic        readout_enable_o,
  output logic        aed_enable_o,
  output logic [7:0]  current_repeat_count_o,
  output logic [15:0] current_data_length_o,
  output logic        current_eof_o,
  output logic        current_sof_o
);
  localparam int AW = $clog2(LUT_DEPTH);

  logic [28:0]   lut [LUT_DEPTH];
  logic [AW-1:0] lut_addr_reg;
  logic [AW:0]   lut_count;
  logic          lut_full;

  seq_state_e  st, st_n;
  logic [7:0]  rep;
  logic [15:0] len, dwell;
  logic        eof, sof, parked, done_q;
  logic [28:0] rd_q;

  logic [AW-1:0] ld_addr;
  logic [28:0]   ld;
  seq_state_e    ld_st;
  logic [15:0]   dwell_max;
  logic          rep_end, has_next;
  logic          do_load, do_done, ptr_inc, rep_dec, dwell_rst, dwell_inc;

  // IDLE fetches the entry under the pointer; an ending entry fetches its successor.
  assign ld_addr   = (st == IDLE) ? lut_addr_reg : lut_addr_reg + AW'(1);
  assign ld        = lut[ld_addr];
  assign ld_st     = seq_state_e'(ld[2:0]);
  assign dwell_max = (len == 16'd0) ? 16'd1 : len;
  assign rep_end   = (dwell >= dwell_max);
  assign has_next  = !eof && (({1'b0, lut_addr_reg} + (AW+1)'(1)) < lut_count);

  always_comb begin
    st_n      = st;
    do_load   = 1'b0;
    do_done   = 1'b0;
    ptr_inc   = 1'b0;
    rep_dec   = 1'b0;
    dwell_rst = 1'b0;
    dwell_inc = 1'b0;
    case (st)
      RST:  st_n = IDLE;
      IDLE: if (!parked && lut_count != '0) do_load = 1'b1;
      default: begin
        if (rep_end) begin
          if (rep > 8'd1) begin
            rep_dec   = 1'b1;
            dwell_rst = 1'b1;
          end else if (has_next) begin
            do_load = 1'b1;
            ptr_inc = 1'b1;
          end else begin
            do_done = 1'b1;
          end
        end else begin
          dwell_inc = 1'b1;
        end
      end
    endcase
    // An entry coded RST/IDLE terminates the sequence on the spot.
    if (do_load) begin
      if (ld_st == RST || ld_st == IDLE) do_done = 1'b1;
      else                               st_n    = ld_st;
    end
    if (do_done) st_n = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!reset_i && lut_wen_i && !lut_full) lut[lut_addr_reg] <= lut_write_data_i;
  end

  always_ff @(posedge clk) begin
    if (!reset_i) begin
      st     <= RST;
      done_q <= 1'b0;
      rd_q   <= '0;
      rep    <= '0;
      len    <= '0;
      dwell  <= '0;
      eof    <= 1'b0;
      sof    <= 1'b0;
      parked <= 1'b0;
      if (lut_wen_i) begin
        if (!lut_full) begin
          lut_count <= {1'b0, lut_addr_reg} + (AW+1)'(1);
          if (lut_addr_reg == AW'(LUT_DEPTH-1)) lut_full     <= 1'b1;
          else                                  lut_addr_reg <= lut_addr_reg + AW'(1);
        end
      end else begin
        lut_addr_reg <= '0;
        lut_full     <= 1'b0;
      end
    end else begin
      st     <= st_n;
      done_q <= do_done;
      if (lut_rden_i) rd_q <= lut[lut_addr_reg];
      if (st == RST) begin
        lut_addr_reg <= '0;
        lut_full     <= 1'b0;
        parked       <= 1'b0;
      end else if (do_done) begin
        lut_addr_reg <= '0;
`ifdef SEQ_AUTO_LOOP_EN
        parked       <= 1'b0;
`else
        parked       <= 1'b1;
`endif
      end else if (ptr_inc) begin
        lut_addr_reg <= lut_addr_reg + AW'(1);
      end
      if (do_load && !do_done) begin
        rep   <= (ld[28:21] == 8'd0) ? 8'd1 : ld[28:21];
        len   <= ld[20:5];
        eof   <= ld[4];
        sof   <= ld[3];
        dwell <= 16'd1;
      end else if (rep_dec) begin
        rep   <= rep - 8'd1;
      end
      if (dwell_rst)      dwell <= 16'd1;
      else if (dwell_inc) dwell <= dwell + 16'd1;
    end
  end

  assign current_state_o        = st;
  assign busy_o                 = (st != RST) && (st != IDLE);
  assign sequence_done_o        = done_q;
  assign lut_read_data_o        = rd_q;
  assign panel_enable_o         = (st == PANEL_STABLE);
  assign bias_enable_o          = (st == BACK_BIAS);
  assign flush_enable_o         = (st == FLUSH);
  assign aed_enable_o           = (st == AED_DETECT);
  assign expose_enable_o        = (st == EXPOSE_TIME);
  assign readout_enable_o       = (st == READOUT);
  assign current_repeat_count_o = busy_o ? rep : 8'd0;
  assign current_data_length_o  = busy_o ? len : 16'd0;
  assign current_eof_o          = busy_o & eof;
  assign current_sof_o          = busy_o & sof;
endmodule

// File: tb/tb_sequencer_fsm.sv
// Directed bench for sequencer_fsm: table load, full sequence timing, empty table, mid-run reset, table read.
module tb_sequencer_fsm;
  logic        clk = 1'b0;
  logic        reset_i;
  logic        lut_wen_i;
  logic [28:0] lut_write_data_i;
  logic        lut_rden_i;
  logic [2:0]  current_state_o;
  logic        busy_o, sequence_done_o;
  logic [28:0] lut_read_data_o;
  logic        panel_enable_o, bias_enable_o, flush_enable_o;
  logic        expose_enable_o, readout_enable_o, aed_enable_o;
  logic [7:0]  current_repeat_count_o;
  logic [15:0] current_data_length_o;
  logic        current_eof_o, current_sof_o;

  int n_chk = 0;
  int n_err = 0;

  sequencer_fsm #(.LUT_DEPTH(16)) dut (
    .clk(clk), .reset_i(reset_i), .lut_wen_i(lut_wen_i), .lut_write_data_i(lut_write_data_i),
    .lut_rden_i(lut_rden_i), .current_state_o(current_state_o), .busy_o(busy_o),
    .sequence_done_o(sequence_done_o), .lut_read_data_o(lut_read_data_o),
    .panel_enable_o(panel_enable_o), .bias_enable_o(bias_enable_o), .flush_enable_o(flush_enable_o),
    .expose_enable_o(expose_enable_o), .readout_enable_o(readout_enable_o), .aed_enable_o(aed_enable_o),
    .current_repeat_count_o(current_repeat_count_o), .current_data_length_o(current_data_length_o),
    .current_eof_o(current_eof_o), .current_sof_o(current_sof_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // cycles spent in 'code' starting from the current cycle; leaves us on the first cycle after
  task automatic measure(input logic [2:0] code, input int budget, output int n);
    n = 0;
    while (current_state_o == code && n < budget) begin n++; tick(); end
  endtask

  function automatic logic [5:0] ens();
    return {panel_enable_o, bias_enable_o, flush_enable_o, expose_enable_o, readout_enable_o, aed_enable_o};
  endfunction

  function automatic logic [33:0] outs();
    return {busy_o, sequence_done_o, ens(), current_repeat_count_o, current_data_length_o,
            current_eof_o, current_sof_o};
  endfunction

  logic [28:0] tbl [5];
  int n, dones;

  initial begin
    tbl[0] = {8'd5, 16'd100,  1'b0, 1'b0, 3'(PANEL_STABLE)};
    tbl[1] = {8'd1, 16'd0,    1'b0, 1'b0, 3'(BACK_BIAS)};
    tbl[2] = {8'd3, 16'd256,  1'b0, 1'b0, 3'(FLUSH)};
    tbl[3] = {8'd1, 16'd5000, 1'b0, 1'b0, 3'(EXPOSE_TIME)};
    tbl[4] = {8'd1, 16'd4096, 1'b1, 1'b0, 3'(READOUT)};
    reset_i = 1'b0; lut_wen_i = 1'b0; lut_write_data_i = '0; lut_rden_i = 1'b0;
    tick(10);
    chk("rst_state", current_state_o, 3'(RST));
    chk("rst_outs", outs(), '0);
    chk("rst_rdata", lut_read_data_o, '0);

    // empty table: release with nothing written
    reset_i = 1'b1;
    tick();
    chk("empty_idle", current_state_o, 3'(IDLE));
    dones = 0;
    repeat (20) begin tick(); if (sequence_done_o) dones++; end
    chk("empty_stay_idle", current_state_o, 3'(IDLE));
    chk("empty_busy", busy_o, 1'b0);
    chk("empty_no_done", dones, 0);

    // load 5 entries during reset
    reset_i = 1'b0;
    tick(2);
    chk("ptr_start", dut.lut_addr_reg, 0);
    for (int i = 0; i < 5; i++) begin
      lut_wen_i = 1'b1; lut_write_data_i = tbl[i];
      tick();
      chk($sformatf("ptr_after_wr%0d", i), dut.lut_addr_reg, i + 1);
    end
    chk("lut_count", dut.lut_count, 5);
    lut_wen_i = 1'b0; reset_i = 1'b1;
    tick();
    chk("cyc1_idle", current_state_o, 3'(IDLE));
    chk("cyc1_ptr", dut.lut_addr_reg, 0);
    tick();
    chk("cyc2_panel", current_state_o, 3'(PANEL_STABLE));
    chk("panel_len", current_data_length_o, 100);
    for (int r = 5; r >= 1; r--) begin
      chk($sformatf("panel_rep%0d_state", r), current_state_o, 3'(PANEL_STABLE));
      chk($sformatf("panel_rep%0d", r), current_repeat_count_o, r);
      tick(100);
    end
    chk("bias_state", current_state_o, 3'(BACK_BIAS));
    chk("bias_en", ens(), 6'b010000);
    measure(3'(BACK_BIAS), 10000, n);
    chk("bias_len", n, 1);
    chk("flush_state", current_state_o, 3'(FLUSH));
    chk("flush_rep", current_repeat_count_o, 3);
    measure(3'(FLUSH), 10000, n);
    chk("flush_len", n, 768);
    chk("expose_state", current_state_o, 3'(EXPOSE_TIME));
    chk("expose_en", ens(), 6'b000100);
    tick(2500);
    chk("expose_en_mid", ens(), 6'b000100);
    measure(3'(EXPOSE_TIME), 10000, n);
    chk("expose_len", n + 2500, 5000);
    chk("readout_state", current_state_o, 3'(READOUT));
    chk("readout_eof", current_eof_o, 1'b1);
    measure(3'(READOUT), 10000, n);
    chk("readout_len", n, 4096);
    chk("done_state", current_state_o, 3'(IDLE));
    chk("done_pulse", sequence_done_o, 1'b1);
    chk("done_busy", busy_o, 1'b0);
    chk("done_outs0", current_repeat_count_o, 0);
    tick();
    chk("done_once", sequence_done_o, 1'b0);
    dones = 0;
    repeat (20) begin tick(); if (sequence_done_o) dones++; end
    chk("parked_idle", current_state_o, 3'(IDLE));
    chk("parked_no_done", dones, 0);

    // rerun to FLUSH, read the table at pointer 2, then reset mid-FLUSH
    reset_i = 1'b0;
    tick();
    reset_i = 1'b1;
    tick(2);
    chk("rerun_panel", current_state_o, 3'(PANEL_STABLE));
    tick(501);
    chk("rerun_flush", current_state_o, 3'(FLUSH));
    chk("rd_ptr", dut.lut_addr_reg, 2);
    lut_rden_i = 1'b1;
    tick();
    lut_rden_i = 1'b0;
    chk("rd_data", lut_read_data_o, {8'd3, 16'd256, 1'b0, 1'b0, 3'd4});
    tick(3);
    chk("rd_hold", lut_read_data_o, {8'd3, 16'd256, 1'b0, 1'b0, 3'd4});
    tick(100);
    reset_i = 1'b0;
    tick();
    chk("midrst_state", current_state_o, 3'(RST));
    chk("midrst_outs", outs(), '0);
    chk("midrst_rdata", lut_read_data_o, '0);
    reset_i = 1'b1;
    tick();
    chk("restart_idle", current_state_o, 3'(IDLE));
    tick();
    chk("restart_panel", current_state_o, 3'(PANEL_STABLE));
    chk("restart_rep", current_repeat_count_o, 5);
    chk("restart_ptr", dut.lut_addr_reg, 0);
    tick(500);
    chk("restart_bias", current_state_o, 3'(BACK_BIAS));
    tick();
    chk("restart_flush", current_state_o, 3'(FLUSH));
    chk("restart_flush_len", current_data_length_o, 256);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
